wb_slave_router: RTL and testbench

// - Parametrised Wishbone classic address router between the arbitrated manager bus and NUM_SLAVES peripherals
//   (SRAM, GPIO, LA, team projects). Decodes each cycle against per-slave base/mask windows, waits for the real

---
 rtl/wb_router_pkg.sv | 41 ++++
 rtl/wb_router_addr_match.sv | 42 ++++
 rtl/wb_slave_router.sv | 200 ++++++++++++++++++++
 tb/tb_wb_slave_router.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_router_pkg.sv
// -----------------------------------------------------------------------------
// wb_router_pkg
// Shared types and constants for the Wishbone slave router.
//   state_t        router FSM encoding (IDLE / ACTIVE / RESP)
//   DEF_SLV_BASE   default flat base map, slice i = base of slave i
//   DEF_SLV_MASK   default flat mask map, slice i = mask of slave i
//   idx_width()    width of a slave index (never below 1)
//   slice_lo()     low bit of slice i in a flat bus of w-bit slices
// -----------------------------------------------------------------------------
package wb_router_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int DEF_NUM_SLAVES = 10;
    localparam int DEF_ADDR_W     = 32;

    // Slave 0 SRAM, 1 GPIO, 2 LA, 3+k team project k.
    localparam logic [DEF_NUM_SLAVES*DEF_ADDR_W-1:0] DEF_SLV_BASE = {
        32'h3060_0000, 32'h3050_0000, 32'h3040_0000, 32'h3030_0000,
        32'h3020_0000, 32'h3010_0000, 32'h3000_0000,
        32'h3100_0000, 32'h3200_0000, 32'h3300_0000
    };

    localparam logic [DEF_NUM_SLAVES*DEF_ADDR_W-1:0] DEF_SLV_MASK = {
        {7{32'hFFF0_0000}},
        {3{32'hFFFF_0000}}
    };

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int slice_lo(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/wb_router_addr_match.sv
// -----------------------------------------------------------------------------
// wb_addr_match
// Combinational address decoder: compares the address against every slave's
// base/mask window and reports the lowest-index match.
//   adr   in   ADDR_W   address to decode
//   hit   out  1        at least one window matches
//   idx   out  IDX_W    index of the lowest matching slave (0 when no hit)
// -----------------------------------------------------------------------------
module wb_addr_match
    import wb_router_pkg::*;
#(
    parameter int                           NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int                           ADDR_W     = DEF_ADDR_W,
    parameter int                           IDX_W      = idx_width(NUM_SLAVES),
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = DEF_SLV_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK   = DEF_SLV_MASK
) (
    input  logic [ADDR_W-1:0] adr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    logic [NUM_SLAVES-1:0] match;

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_match
        assign match[g] = ((adr & SLV_MASK[slice_lo(g, ADDR_W) +: ADDR_W])
                           == SLV_BASE[slice_lo(g, ADDR_W) +: ADDR_W]);
    end

    // Scan from the top down so the lowest matching index is written last.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit = 1'b1;
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/wb_slave_router.sv
// -----------------------------------------------------------------------------
// wb_slave_router
// Wishbone classic router between the arbitrated manager bus and NUM_SLAVES
// peripherals. Each request is decoded against the base/mask windows, routed
// to the winning slave until it acks, and answered with a registered ack/err.
// Unmapped addresses and slaves silent for TIMEOUT_CYC cycles get an error.
//
// Ports
//   CLK, RST                      clock, synchronous active-high reset
//   m_cyc_i/stb_i/we_i            manager cycle, strobe, write enable
//   m_adr_i/dat_i/sel_i           manager address, write data, byte selects
//   m_ack_o/err_o/dat_o           registered response to manager
//   s_cyc_o/stb_o/we_o            per-slave control (one bit per slave)
//   s_adr_o/dat_o/sel_o           flat per-slave buses, slice i to slave i
//   s_ack_i, s_dat_i              per-slave ack and flat read data
//   timeout_o                     pulses with m_err_o on a slave timeout
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no transfer; waiting for cyc & stb, slave outputs quiet
// ACTIVE | selected slave driven from the manager, waiting for its ack
// RESP   | one-cycle ack or err presented to the manager
// -----------------------------------------------------------------------------
module wb_slave_router
    import wb_router_pkg::*;
#(
    parameter int                           NUM_SLAVES  = DEF_NUM_SLAVES,
    parameter int                           ADDR_W      = DEF_ADDR_W,
    parameter int                           DATA_W      = 32,
    parameter int                           SEL_W       = DATA_W / 8,
    parameter int                           TIMEOUT_CYC = 255,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE    = DEF_SLV_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK    = DEF_SLV_MASK
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         m_cyc_i,
    input  logic                         m_stb_i,
    input  logic                         m_we_i,
    input  logic [ADDR_W-1:0]            m_adr_i,
    input  logic [DATA_W-1:0]            m_dat_i,
    input  logic [SEL_W-1:0]             m_sel_i,
    output logic                         m_ack_o,
    output logic                         m_err_o,
    output logic [DATA_W-1:0]            m_dat_o,
    output logic [NUM_SLAVES-1:0]        s_cyc_o,
    output logic [NUM_SLAVES-1:0]        s_stb_o,
    output logic [NUM_SLAVES-1:0]        s_we_o,
    output logic [NUM_SLAVES*ADDR_W-1:0] s_adr_o,
    output logic [NUM_SLAVES*DATA_W-1:0] s_dat_o,
    output logic [NUM_SLAVES*SEL_W-1:0]  s_sel_o,
    input  logic [NUM_SLAVES-1:0]        s_ack_i,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_dat_i,
    output logic                         timeout_o
);

    localparam int IDX_W = idx_width(NUM_SLAVES);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    // The counter holds the number of ACTIVE cycles already completed, so the
    // cycle in which it equals CNT_LAST is the TIMEOUT_CYC-th ACTIVE cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

    state_t              state;
    state_t              state_next;
    logic [IDX_W-1:0]    sel_idx;
    logic [CNT_W-1:0]    cnt;
    logic                ack_q;
    logic                err_q;
    logic                tmo_q;
    logic [DATA_W-1:0]   rdat_q;

    logic                dec_hit;
    logic [IDX_W-1:0]    dec_idx;
    logic [NUM_SLAVES-1:0] sel_onehot;
    logic [NUM_SLAVES-1:0] live;
    logic                sel_ack;
    logic [DATA_W-1:0]   sel_rdat;
    logic                active;
    logic                load_sel;
    logic                go_ack;
    logic                go_err;
    logic                go_tmo;

    wb_addr_match #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_addr_match (
        .adr (m_adr_i),
        .hit (dec_hit),
        .idx (dec_idx)
    );

    assign active = (state == ACTIVE);

    // Fan-out: only the latched slave sees the manager, and only in ACTIVE.
    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_fan
        assign sel_onehot[g] = (sel_idx == IDX_W'(g));
        assign live[g]       = active & sel_onehot[g];
        assign s_cyc_o[g]    = live[g] & m_cyc_i;
        assign s_stb_o[g]    = live[g] & m_stb_i;
        assign s_we_o[g]     = live[g] & m_we_i;
        assign s_adr_o[slice_lo(g, ADDR_W) +: ADDR_W] = live[g] ? m_adr_i : '0;
        assign s_dat_o[slice_lo(g, DATA_W) +: DATA_W] = live[g] ? m_dat_i : '0;
        assign s_sel_o[slice_lo(g, SEL_W)  +: SEL_W]  = live[g] ? m_sel_i : '0;
    end

    // Acks from slaves other than the latched one never reach the FSM.
    assign sel_ack = |(s_ack_i & sel_onehot);

    always_comb begin
        sel_rdat = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (sel_onehot[k]) begin
                sel_rdat = s_dat_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_sel   = 1'b0;
        go_ack     = 1'b0;
        go_err     = 1'b0;
        go_tmo     = 1'b0;
        case (state)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    if (dec_hit) begin
                        load_sel   = 1'b1;
                        state_next = ACTIVE;
                    end else begin
                        go_err     = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            ACTIVE: begin
                // Abort beats everything; an ack in the final cycle beats timeout.
                if (!m_cyc_i) begin
                    state_next = IDLE;
                end else if (sel_ack) begin
                    go_ack     = 1'b1;
                    state_next = RESP;
                end else if (cnt == CNT_LAST) begin
                    go_err     = 1'b1;
                    go_tmo     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sel_idx <= '0;
            cnt     <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            if (load_sel) begin
                sel_idx <= dec_idx;
                cnt     <= '0;
            end else if (active && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end
            // Response flags live for exactly the RESP cycle.
            ack_q  <= go_ack;
            err_q  <= go_err;
            tmo_q  <= go_tmo;
            rdat_q <= (go_ack && !m_we_i) ? sel_rdat : '0;
        end
    end

    assign m_ack_o   = ack_q;
    assign m_err_o   = err_q;
    assign m_dat_o   = rdat_q;
    assign timeout_o = tmo_q;

endmodule

// File: tb/tb_wb_slave_router.sv
module tb_wb_slave_router;

    localparam int NS  = 10;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 8;

    // Default map except slave 9, which is widened to all of 0x3xxx_xxxx so
    // that it overlaps lower-index windows and exercises priority.
    localparam logic [NS*AW-1:0] P_BASE = {
        32'h3000_0000, 32'h3050_0000, 32'h3040_0000, 32'h3030_0000,
        32'h3020_0000, 32'h3010_0000, 32'h3000_0000,
        32'h3100_0000, 32'h3200_0000, 32'h3300_0000
    };
    localparam logic [NS*AW-1:0] P_MASK = {
        32'hF000_0000, {6{32'hFFF0_0000}}, {3{32'hFFFF_0000}}
    };

    logic              clk;
    logic              rst;
    logic              m_cyc, m_stb, m_we;
    logic [AW-1:0]     m_adr;
    logic [DW-1:0]     m_dat;
    logic [SW-1:0]     m_sel;
    logic              m_ack_o, m_err_o, timeout_o;
    logic [DW-1:0]     m_dat_o;
    logic [NS-1:0]     s_cyc_o, s_stb_o, s_we_o, s_ack_i;
    logic [NS*AW-1:0]  s_adr_o;
    logic [NS*DW-1:0]  s_dat_o, s_dat_i;
    logic [NS*SW-1:0]  s_sel_o;

    logic [31:0] ref_base [NS];
    logic [31:0] ref_mask [NS];

    int n_cmp = 0;
    int n_bad = 0;

    wb_slave_router #(
        .NUM_SLAVES  (NS),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .SEL_W       (SW),
        .TIMEOUT_CYC (TMO),
        .SLV_BASE    (P_BASE),
        .SLV_MASK    (P_MASK)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .m_cyc_i   (m_cyc),
        .m_stb_i   (m_stb),
        .m_we_i    (m_we),
        .m_adr_i   (m_adr),
        .m_dat_i   (m_dat),
        .m_sel_i   (m_sel),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .m_dat_o   (m_dat_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_ack_i   (s_ack_i),
        .s_dat_i   (s_dat_i),
        .timeout_o (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the window rule: lowest index wins.
    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & ref_mask[i]) == ref_base[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_resp"}, {m_ack_o, m_err_o, timeout_o, m_dat_o}, '0);
        chk({tag, "_sctl"}, {s_cyc_o, s_stb_o, s_we_o}, '0);
        chk({tag, "_sadr"}, s_adr_o, '0);
        chk({tag, "_sdat"}, s_dat_o, '0);
        chk({tag, "_ssel"}, s_sel_o, '0);
    endtask

    task automatic rand_sdat();
        for (int j = 0; j < NS; j++) s_dat_i[j*DW +: DW] = $urandom;
    endtask

    // One complete transfer. waits = slave wait states before its ack.
    task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                        input logic [31:0] wdat, input logic [3:0] sel,
                        input int waits, input logic [31:0] rdat);
        int            tgt;
        int            n_active;
        bit            exp_ack;
        logic [NS-1:0] oh;
        logic [NS*AW-1:0] e_adr;
        logic [NS*DW-1:0] e_dat;
        logic [NS*SW-1:0] e_sel;

        tgt   = ref_decode(adr);
        oh    = '0;
        e_adr = '0;
        e_dat = '0;
        e_sel = '0;
        if (tgt >= 0) begin
            oh[tgt] = 1'b1;
            e_adr[tgt*AW +: AW] = adr;
            e_dat[tgt*DW +: DW] = wdat;
            e_sel[tgt*SW +: SW] = sel;
        end
        if (tgt < 0) begin
            n_active = 0;
            exp_ack  = 1'b0;
        end else if (waits + 1 <= TMO) begin
            n_active = waits + 1;
            exp_ack  = 1'b1;
        end else begin
            n_active = TMO;
            exp_ack  = 1'b0;
        end

        @(negedge clk);
        m_cyc = 1'b1; m_stb = 1'b1; m_we = we;
        m_adr = adr; m_dat = wdat; m_sel = sel;
        #1;
        chk({tag, "_req_scyc"}, s_cyc_o, '0);

        for (int c = 1; c <= n_active; c++) begin
            @(negedge clk);
            chk({tag, "_scyc"}, s_cyc_o, oh);
            chk({tag, "_sstb"}, s_stb_o, oh);
            chk({tag, "_swe"},  s_we_o, we ? oh : '0);
            chk({tag, "_sadr"}, s_adr_o, e_adr);
            chk({tag, "_sdat"}, s_dat_o, e_dat);
            chk({tag, "_ssel"}, s_sel_o, e_sel);
            chk({tag, "_early"}, {m_ack_o, m_err_o, timeout_o}, '0);
            rand_sdat();
            if (exp_ack && c == waits + 1) begin
                s_ack_i = (NS'($urandom) & ~oh) | oh;
                s_dat_i[tgt*DW +: DW] = rdat;
            end else begin
                s_ack_i = NS'($urandom) & ~oh;
            end
        end

        @(negedge clk);
        chk({tag, "_ack"}, m_ack_o, exp_ack);
        chk({tag, "_err"}, m_err_o, !exp_ack);
        chk({tag, "_tmo"}, timeout_o, (tgt >= 0) && !exp_ack);
        chk({tag, "_mdat"}, m_dat_o, (exp_ack && !we) ? rdat : 32'h0);
        chk({tag, "_resp_scyc"}, s_cyc_o, '0);
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        s_ack_i = NS'($urandom);

        @(negedge clk);
        chk_quiet({tag, "_after"});
        s_ack_i = '0;
    endtask

    initial begin
        logic        we;
        logic [31:0] adr;
        int          r;

        ref_base = '{32'h3300_0000, 32'h3200_0000, 32'h3100_0000, 32'h3000_0000,
                     32'h3010_0000, 32'h3020_0000, 32'h3030_0000, 32'h3040_0000,
                     32'h3050_0000, 32'h3000_0000};
        ref_mask = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFF0_0000,
                     32'hFFF0_0000, 32'hFFF0_0000, 32'hFFF0_0000, 32'hFFF0_0000,
                     32'hFFF0_0000, 32'hF000_0000};

        rst = 1'b1; m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        m_adr = '0; m_dat = '0; m_sel = '0; s_ack_i = '0; s_dat_i = '0;
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("post_reset");

        xfer("gpio_read", 1'b0, 32'h3200_0004, 32'h5555_AAAA, 4'hF, 0, 32'hDEAD_BEEF);
        xfer("team3_write", 1'b1, 32'h3030_0010, 32'h1234_5678, 4'hF, 4, 32'hCAFE_F00D);
        xfer("unmapped", 1'b0, 32'h4000_0000, 32'h0, 4'hF, 0, 32'h1111_1111);
        xfer("sram_timeout", 1'b0, 32'h3300_0000, 32'h0, 4'hF, 100, 32'h2222_2222);
        xfer("ack_at_limit", 1'b0, 32'h3300_0040, 32'h0, 4'h3, TMO - 1, 32'hA5A5_5A5A);
        xfer("prio_slave9", 1'b0, 32'h3070_0000, 32'h0, 4'h1, 2, 32'h0BAD_CAFE);

        // Manager abort in the second ACTIVE cycle.
        @(negedge clk);
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h3100_0008; m_sel = 4'hF;
        @(negedge clk);
        chk("abort_a1_scyc", s_cyc_o, 10'b00_0000_0100);
        @(negedge clk);
        chk("abort_a2_scyc", s_cyc_o, 10'b00_0000_0100);
        m_cyc = 1'b0; m_stb = 1'b0;
        #1;
        chk("abort_drop_scyc", s_cyc_o, '0);
        @(negedge clk);
        chk("abort_n1_resp", {s_cyc_o, m_ack_o, m_err_o, timeout_o}, '0);
        @(negedge clk);
        chk("abort_n2_resp", {s_cyc_o, m_ack_o, m_err_o, timeout_o}, '0);
        xfer("after_abort", 1'b0, 32'h3200_0100, 32'h0, 4'hF, 1, 32'h7777_0001);

        // Reset asserted mid-ACTIVE.
        @(negedge clk);
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_adr = 32'h3200_0000;
        m_dat = 32'h0F0F_0F0F; m_sel = 4'hC;
        @(negedge clk);
        chk("rstmid_a1_sstb", s_stb_o, 10'b00_0000_0010);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("rstmid");
        rst = 1'b0; m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        @(negedge clk);
        chk_quiet("rstmid_idle");
        xfer("after_rst", 1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 32'h3141_5926);

        // Randomised traffic against the reference decode and timing rules.
        for (int t = 0; t < 40; t++) begin
            r  = $urandom_range(0, 11);
            we = 1'($urandom);
            if (r < NS) adr = ref_base[r] | ($urandom & ~ref_mask[r]);
            else        adr = $urandom;
            xfer("rand", we, adr, $urandom, 4'($urandom), $urandom_range(0, TMO + 2), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
